// File: rtl/updown_pkg.sv
// rtl/updown_pkg.sv - shared FSM encodings and step direction constants
package updown_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMP   = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CMP   = ST_CMP,
    PULSE = ST_PULSE,
    GAP   = ST_GAP,
    DONE  = ST_DONE
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/step_gap_timer.sv
// rtl/step_gap_timer.sv - loadable down-counter timing the idle gap between step pulses
module step_gap_timer #(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             enable,
  output logic             expired
);

  logic [GAP_W-1:0] cnt_q;
  logic [GAP_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is flagged during the last gap cycle so the FSM reaches CMP right after it.
  assign expired = (cnt_q <= GAP_W'(1));

endmodule

// File: rtl/updown_step_driver.sv
// rtl/updown_step_driver.sv - emits up/down step pulses until the shadow position reaches the target
module updown_step_driver
  import updown_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic [GAP_W-1:0] gap,
  input  logic             load,
  input  logic             abort,
  input  logic             pos_clr,
  output logic             up,
  output logic             down,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] position
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] position_q, position_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             dir_q, dir_d;
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_expired;

  step_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (gap_q),
    .enable   (tmr_en),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    position_d = position_q;
    gap_d      = gap_q;
    dir_d      = dir_q;
    up_d       = 1'b0;
    down_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pos_clr) begin
          position_d = '0;
        end else if (load) begin
          target_d = target;
          gap_d    = gap;
          state_d  = CMP;
        end
      end
      CMP: begin
        if (abort || (target_q == position_q)) begin
          state_d = DONE;
        end else begin
          state_d = PULSE;
          dir_d   = (target_q > position_q) ? DIR_UP : DIR_DOWN;
          up_d    = (target_q > position_q);
          down_d  = !(target_q > position_q);
        end
      end
      PULSE: begin
        // The pulse is already on the wire, so position tracks it even when aborting.
        position_d = (dir_q == DIR_UP) ? position_q + WIDTH'(1) : position_q - WIDTH'(1);
        if (abort) begin
          state_d = DONE;
        end else if (gap_q == '0) begin
          state_d = CMP;
        end else begin
          state_d  = GAP;
          tmr_load = 1'b1;
        end
      end
      GAP: begin
        tmr_en = 1'b1;
        if (abort) begin
          state_d = DONE;
        end else if (tmr_expired) begin
          state_d = CMP;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      target_q   <= '0;
      position_q <= '0;
      gap_q      <= '0;
      dir_q      <= DIR_UP;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      position_q <= position_d;
      gap_q      <= gap_d;
      dir_q      <= dir_d;
      up_q       <= up_d;
      down_q     <= down_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign up       = up_q;
  assign down     = down_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign position = position_q;

endmodule

// File: tb/tb_updown_step_driver.sv
// tb/tb_updown_step_driver.sv - self-checking bench for updown_step_driver
module tb_updown_step_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] target;
  logic [7:0] gap;
  logic       load;
  logic       abort;
  logic       pos_clr;
  logic       up;
  logic       down;
  logic       busy;
  logic       done;
  logic [7:0] position;

  int tests = 0;
  int fails = 0;
  int pos_m = 0;

  updown_step_driver #(.WIDTH(8), .GAP_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .target   (target),
    .gap      (gap),
    .load     (load),
    .abort    (abort),
    .pos_clr  (pos_clr),
    .up       (up),
    .down     (down),
    .busy     (busy),
    .done     (done),
    .position (position)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected waveform is derived from the step schedule: pulse k sits in cycle 2+k*(2+gap),
  // done sits in cycle 2+n*(2+gap), or one cycle after the aborted pulse.
  task automatic move(input int t, input int g, input int ak);
    int  n, per, done_c, pb, p0;
    bit  is_up, pulse_now;
    p0    = pos_m;
    is_up = (t > p0);
    n     = is_up ? t - p0 : p0 - t;
    per   = 2 + g;
    if (ak >= 0 && ak < n) begin
      n      = ak + 1;
      done_c = 2 + ak * per + 1;
    end else begin
      ak     = -1;
      done_c = 2 + n * per;
    end
    @(posedge clk); #1;
    load = 1'b1; target = 8'(t); gap = 8'(g);
    for (int c = 0; c <= done_c + 1; c++) begin
      @(negedge clk);
      pb = (c < 3) ? 0 : ((c - 3) / per + 1);
      if (pb > n) pb = n;
      pulse_now = (c >= 2) && ((c - 2) % per == 0) && ((c - 2) / per < n);
      chk($sformatf("up t=%0d g=%0d c=%0d", t, g, c), 32'(up), 32'(pulse_now && is_up));
      chk($sformatf("down t=%0d g=%0d c=%0d", t, g, c), 32'(down), 32'(pulse_now && !is_up));
      chk($sformatf("busy t=%0d g=%0d c=%0d", t, g, c), 32'(busy), 32'(c >= 1 && c <= done_c));
      chk($sformatf("done t=%0d g=%0d c=%0d", t, g, c), 32'(done), 32'(c == done_c));
      chk($sformatf("pos t=%0d g=%0d c=%0d", t, g, c), 32'(position), 32'(is_up ? p0 + pb : p0 - pb));
      @(posedge clk); #1;
      load = 1'b0; abort = 1'b0; pos_clr = 1'b0;
      if (ak >= 0 && c + 1 == 2 + ak * per) abort = 1'b1;
      if (c + 1 <= done_c && $urandom_range(0, 3) == 0) begin
        load = 1'b1; pos_clr = 1'b1; target = 8'($urandom); gap = 8'($urandom);
      end
    end
    pos_m = is_up ? p0 + n : p0 - n;
  endtask

  initial begin
    int t;
    reset = 1'b1; target = '0; gap = '0; load = 1'b0; abort = 1'b0; pos_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst up", 32'(up), 0);
    chk("rst down", 32'(down), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst pos", 32'(position), 0);
    @(posedge clk); #1 reset = 1'b0;

    move(3, 0, -1);
    move(1, 2, -1);
    move(1, 0, -1);

    // load together with pos_clr in IDLE: clear wins, no move starts
    @(posedge clk); #1 load = 1'b1; pos_clr = 1'b1; target = 8'd7;
    @(posedge clk); #1 load = 1'b0; pos_clr = 1'b0;
    @(negedge clk);
    chk("clr+load busy", 32'(busy), 0);
    chk("clr+load pos", 32'(position), 0);
    pos_m = 0;

    move(5, 0, 1);

    // reset asserted mid-gap of a move toward 10
    @(posedge clk); #1 load = 1'b1; target = 8'd10; gap = 8'd3;
    @(posedge clk); #1 load = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst up", 32'(up), 0);
    chk("midrst down", 32'(down), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst pos", 32'(position), 0);
    @(posedge clk); #1 reset = 1'b0;
    pos_m = 0;

    move(2, 1, -1);

    @(posedge clk); #1 pos_clr = 1'b1;
    @(posedge clk); #1 pos_clr = 1'b0;
    @(negedge clk);
    chk("idle clr pos", 32'(position), 0);
    pos_m = 0;

    move(255, 0, -1);
    move(250, 1, -1);

    for (int i = 0; i < 10; i++) begin
      t = pos_m + int'($urandom_range(0, 20)) - 10;
      if (t < 0) t = 0;
      if (t > 255) t = 255;
      move(t, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
